mult_ram_sequencer: RTL
=======================

MULT_RAM_SEQUENCER -- requirements
Module: mult_ram_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL have these parameters:
  - DATA_W, default 32, word width.
  - ADDR_W, default 4, RAM index width (depth 2^ADDR_W).
  - MULT_LAT, default 3, multiplier pipeline depth (MULT_LAT >= 1).
REQ-003 The block SHALL have these ports:
  - CLK  in  1  clock.
  - RESET  in  1  synchronous active-high reset.
  - WRITE_F  in  1  host register write strobe.
  - ADDR  in  4  host register select.
  - WRITE_DATA  in  DATA_W  host write data.
  - READ_DATA  out  DATA_W  host read data, combinational from ADDR.
  - RAM_ADDR  out  ADDR_W  dual-port RAM port-B address.
  - RAM_RD_EN  out  1  RAM read request; data valid one cycle later.
  - RAM_RDATA  in  DATA_W  RAM read data.
  - RAM_WE  out  1  RAM write enable.
  - RAM_WDATA  out  DATA_W  RAM write data.
  - IRQ  out  1  level interrupt, equal to STATUS.DONE & CONTROL.IRQ_EN.

Function
REQ-004 The register map SHALL be:
  - 0 CONTROL: bit0 START (self-clearing), bit1 MODE (0 elementwise, 1 dot product), bit2 ABORT (self-clearing), bit3 IRQ_EN.
  - 1 SRC_A, 2 SRC_B, 3 DST: ADDR_W-bit base indices.
  - 4 LENGTH: ADDR_W+1 bits.
  - 5 STATUS: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 OVF; bits1-3 clear on a write of 1 (W1C).
  - 6 RESULT (read-only).
  - 7 COUNT (read-only, elements completed).
  - Addresses 8-15 read 0 and ignore writes.
REQ-005 Unused register bits SHALL read 0.
REQ-006 LENGTH writes above 2^ADDR_W SHALL saturate to 2^ADDR_W.
REQ-007 The state machine SHALL have the states IDLE, RD_A, RD_B, CAP_B, MUL, WR, FINAL, DONE.
REQ-008 In IDLE, a WRITE_F to CONTROL with START=1 SHALL perform these actions on the next clock edge:
  - latch MODE;
  - clear index i, COUNT, accumulator, DONE and OVF;
  - set BUSY;
  - enter RD_A.
REQ-009 RD_A SHALL assert RAM_RD_EN with RAM_ADDR=(SRC_A+i) mod 2^ADDR_W for one cycle.
REQ-010 RD_B SHALL assert RAM_RD_EN with RAM_ADDR=(SRC_B+i) mod 2^ADDR_W and SHALL capture RAM_RDATA as operand A.
REQ-011 CAP_B SHALL capture RAM_RDATA as operand B.
REQ-012 MUL SHALL last exactly MULT_LAT cycles and SHALL form the unsigned product P=A*B, 2*DATA_W bits wide.
REQ-013 In WR with MODE=0, the block SHALL do the following:
  - assert RAM_WE for one cycle with RAM_ADDR=(DST+i) mod 2^ADDR_W and RAM_WDATA=P[DATA_W-1:0];
  - set RESULT=P[DATA_W-1:0].
REQ-014 In WR with MODE=1, the block SHALL set acc=(acc+P[DATA_W-1:0]) mod 2^DATA_W and SHALL not write the RAM.
REQ-015 Leaving WR SHALL increment i and COUNT.
REQ-016 On leaving WR, the block SHALL go to RD_A if i<LENGTH; otherwise to FINAL if MODE=1, or to DONE if MODE=0.
REQ-017 Each element SHALL take exactly 4+MULT_LAT cycles, from RD_A entry to the next RD_A entry.
REQ-018 FINAL SHALL write acc to RAM at DST, set RESULT=acc, and go to DONE.
REQ-019 DONE SHALL set STATUS.DONE, clear BUSY, and return to IDLE after one cycle.
REQ-020 OVF SHALL set (sticky) when P[2*DATA_W-1:DATA_W] is nonzero or the accumulate carries out.
REQ-021 A START with LENGTH=0 SHALL go directly to DONE with no RAM access and RESULT unchanged.
REQ-022 A START while BUSY SHALL be ignored and SHALL set ERR.
REQ-023 Writes to SRC_A, SRC_B, DST or LENGTH while BUSY SHALL be ignored and SHALL set ERR.
REQ-024 On an ABORT write while BUSY, the next edge SHALL enter IDLE with these effects:
  - BUSY=0;
  - DONE not set;
  - no RAM_WE in that cycle or any later cycle;
  - COUNT holds the number of elements completed.
REQ-025 If the same write sets both START=1 and ABORT=1, ABORT SHALL win.
REQ-026 If the DONE-setting cycle coincides with a W1C write to DONE, the set SHALL win.
REQ-027 RAM_RD_EN and RAM_WE SHALL never be asserted in the same cycle.

Reset
REQ-028 When RESET is high at a clock edge, the block SHALL:
  - enter IDLE;
  - clear all registers, i, acc and COUNT;
  - drive RAM_RD_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0 and IRQ=0.
REQ-029 RESET SHALL take effect mid-operation with no further RAM write.

Verification
REQ-030 The bench SHALL cover these directed scenarios with DATA_W=32, ADDR_W=4, MULT_LAT=3:
  - Elementwise: RAM[0..3]={1,2,3,4}, RAM[4..7]={5,6,7,8}, SRC_A=0, SRC_B=4, DST=8, LENGTH=4, MODE=0 -> RAM[8..11]={5,12,21,32}; DONE rises 29 cycles after the START write edge (4 elements x 7 cycles + DONE cycle); COUNT=4; OVF=0.
  - Dot product: same data, MODE=1, DST=12 -> RAM[12]=70; RESULT=70; exactly one RAM write.
  - Wrap and overflow: SRC_A=15, SRC_B=14, DST=15, LENGTH=2, RAM[15]=0xFFFF_FFFF, RAM[0]=2, RAM[14]=2 -> element 0 reads indices 15/14 and element 1 reads 0/15; RAM[15]=0xFFFF_FFFE; OVF=1.
  - Protection: START again while BUSY -> ERR=1 and the run completes unchanged; then W1C 0x4 to STATUS -> ERR=0.
  - Abort: LENGTH=8, ABORT written after the second WR -> BUSY=0 next cycle, DONE=0, COUNT=2, no further RAM_WE.
  - Reset mid-run and zero length: RESET asserted during MUL -> all outputs 0 next cycle; a subsequent START with LENGTH=0 -> DONE within 2 cycles and no RAM strobes.

Source files
------------

// File: rtl/mult_ram_sequencer.sv
// Register-programmed sequencer that multiplies vectors held in a dual-port RAM,
// either elementwise into a destination vector or accumulated into a dot product.
module mult_ram_sequencer #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int MULT_LAT = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE_F,
   input  logic [3:0]        ADDR,
   input  logic [DATA_W-1:0] WRITE_DATA,
   output logic [DATA_W-1:0] READ_DATA,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_RD_EN,
   input  logic [DATA_W-1:0] RAM_RDATA,
   output logic              RAM_WE,
   output logic [DATA_W-1:0] RAM_WDATA,
   output logic              IRQ
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_LAT - 1);

   typedef enum logic [2:0] {
      IDLE, RD_A, RD_B, CAP_B, MUL, WR, FINAL, DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_a, src_b, dst;
   logic [LEN_W-1:0]  length, idx, count, idx_next;
   logic              mode_reg, irq_en, run_mode;
   logic              busy, done, err, ovf;
   logic [DATA_W-1:0] op_a, op_b, acc, result;
   logic [CNT_W-1:0]  mul_cnt;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W:0]   acc_sum;
   logic              ctrl_wr, start_req, abort_req, cfg_wr;

   // Host bus: a register write takes effect on the edge where WRITE_F is high;
   // reads are combinational from ADDR with no strobe. There is no backpressure.
   assign ctrl_wr   = WRITE_F && (ADDR == 4'd0);
   assign abort_req = ctrl_wr && WRITE_DATA[2];
   assign start_req = ctrl_wr && WRITE_DATA[0] && !WRITE_DATA[2];
   assign cfg_wr    = WRITE_F && (ADDR >= 4'd1) && (ADDR <= 4'd4);

   // Operands stay frozen through MUL, so this product path has MULT_LAT cycles to settle.
   assign prod     = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
   assign acc_sum  = {1'b0, acc} + {1'b0, prod[DATA_W-1:0]};
   assign idx_next = idx + LEN_W'(1);
   assign IRQ      = done & irq_en;

   always_comb begin
      READ_DATA = '0;
      case (ADDR)
         4'd0:    READ_DATA = DATA_W'({irq_en, 1'b0, mode_reg, 1'b0});
         4'd1:    READ_DATA = DATA_W'(src_a);
         4'd2:    READ_DATA = DATA_W'(src_b);
         4'd3:    READ_DATA = DATA_W'(dst);
         4'd4:    READ_DATA = DATA_W'(length);
         4'd5:    READ_DATA = DATA_W'({ovf, err, done, busy});
         4'd6:    READ_DATA = result;
         4'd7:    READ_DATA = DATA_W'(count);
         default: READ_DATA = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         src_a     <= '0;
         src_b     <= '0;
         dst       <= '0;
         length    <= '0;
         idx       <= '0;
         count     <= '0;
         mode_reg  <= 1'b0;
         irq_en    <= 1'b0;
         run_mode  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         ovf       <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         acc       <= '0;
         result    <= '0;
         mul_cnt   <= '0;
         RAM_ADDR  <= '0;
         RAM_RD_EN <= 1'b0;
         RAM_WE    <= 1'b0;
         RAM_WDATA <= '0;
      end else begin
         RAM_RD_EN <= 1'b0;
         RAM_WE    <= 1'b0;

         if (WRITE_F) begin
            case (ADDR)
               4'd0: begin
                  mode_reg <= WRITE_DATA[1];
                  irq_en   <= WRITE_DATA[3];
               end
               4'd1: if (!busy) src_a <= WRITE_DATA[ADDR_W-1:0];
               4'd2: if (!busy) src_b <= WRITE_DATA[ADDR_W-1:0];
               4'd3: if (!busy) dst <= WRITE_DATA[ADDR_W-1:0];
               4'd4: if (!busy) length <= (WRITE_DATA > DATA_W'(DEPTH)) ?
                                          LEN_MAX : WRITE_DATA[LEN_W-1:0];
               4'd5: begin
                  if (WRITE_DATA[1]) done <= 1'b0;
                  if (WRITE_DATA[2]) err  <= 1'b0;
                  if (WRITE_DATA[3]) ovf  <= 1'b0;
               end
               default: ;
            endcase
         end
         if (busy && (start_req || cfg_wr)) err <= 1'b1;

         // Status sets below are placed after the W1C path so a coincident set wins.
         if (abort_req && busy) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start_req) begin
                  run_mode <= WRITE_DATA[1];
                  idx      <= '0;
                  count    <= '0;
                  acc      <= '0;
                  done     <= 1'b0;
                  ovf      <= 1'b0;
                  busy     <= 1'b1;
                  if (length == '0) begin
                     state <= DONE;
                  end else begin
                     state     <= RD_A;
                     RAM_RD_EN <= 1'b1;
                     RAM_ADDR  <= src_a;
                  end
               end
               RD_A: begin
                  state     <= RD_B;
                  RAM_RD_EN <= 1'b1;
                  RAM_ADDR  <= src_b + idx[ADDR_W-1:0];
               end
               RD_B: begin
                  op_a  <= RAM_RDATA;
                  state <= CAP_B;
               end
               CAP_B: begin
                  op_b    <= RAM_RDATA;
                  mul_cnt <= '0;
                  state   <= MUL;
               end
               MUL: begin
                  if (mul_cnt == MUL_LAST) begin
                     state <= WR;
                     if (!run_mode) begin
                        RAM_WE    <= 1'b1;
                        RAM_ADDR  <= dst + idx[ADDR_W-1:0];
                        RAM_WDATA <= prod[DATA_W-1:0];
                     end
                  end else begin
                     mul_cnt <= mul_cnt + CNT_W'(1);
                  end
               end
               WR: begin
                  if (|prod[2*DATA_W-1:DATA_W]) ovf <= 1'b1;
                  if (run_mode) begin
                     acc <= acc_sum[DATA_W-1:0];
                     if (acc_sum[DATA_W]) ovf <= 1'b1;
                  end else begin
                     result <= prod[DATA_W-1:0];
                  end
                  idx   <= idx_next;
                  count <= count + LEN_W'(1);
                  if (idx_next < length) begin
                     state     <= RD_A;
                     RAM_RD_EN <= 1'b1;
                     RAM_ADDR  <= src_a + idx_next[ADDR_W-1:0];
                  end else if (run_mode) begin
                     state     <= FINAL;
                     RAM_WE    <= 1'b1;
                     RAM_ADDR  <= dst;
                     RAM_WDATA <= acc_sum[DATA_W-1:0];
                  end else begin
                     state <= DONE;
                  end
               end
               FINAL: begin
                  result <= acc;
                  state  <= DONE;
               end
               DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
